exmem_pipe_reg: RTL and testbench

Parametrised, elastic EX/MEM pipeline register for the pipelined processor. It replaces the fixed always-load EX/MEM latch with a valid/ready handshake stage that has an optional skid slot, a synchronous flush, and a qualified forwarding tag. It sits between the execute stage (ALU, store-data mux) and the data-memory stage, and feeds the forwarding unit.

---
 rtl/exmem_pipe_reg.sv | 135 +++++++++++++
 tb/tb_exmem_pipe_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_pipe_reg.sv
// exmem_pipe_reg: elastic EX/MEM pipeline register with valid/ready handshake.
//
// Holds up to two entries (main + skid) when SKID=1, or one entry when SKID=0.
// Entries leave in order. A synchronous flush kills every held entry. The
// control bundle is gated by out_valid, so a bubble never drives memwrite,
// memread or regwrite. fwd_regwrite is a qualified tag for the forwarding unit.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   flush                 synchronous kill of all held entries
//   in_valid, in_ready    upstream handshake from EX
//   ctrl_in               control bundle {.., memread, memwrite, memtoreg, regwrite}
//   aluresult_in          ALU result / memory address
//   storedata_in          store data after forwarding
//   rd_in                 destination register
//   out_valid, out_ready  downstream handshake to MEM
//   ctrl_out              head control bundle, zero while out_valid is low
//   aluresult_out         head ALU result
//   storedata_out         head store data
//   rd_out                head destination register
//   fwd_regwrite          out_valid & regwrite & (rd_out != 0)
//   occupancy             number of held entries (0..2)
module exmem_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CTRLW = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTRLW-1:0] ctrl_in,
  input  logic [XLEN-1:0]  aluresult_in,
  input  logic [XLEN-1:0]  storedata_in,
  input  logic [REGW-1:0]  rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] ctrl_out,
  output logic [XLEN-1:0]  aluresult_out,
  output logic [XLEN-1:0]  storedata_out,
  output logic [REGW-1:0]  rd_out,
  output logic             fwd_regwrite,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  // Payload packed as {ctrl, aluresult, storedata, rd}.
  localparam int unsigned PW = CTRLW + 2 * XLEN + REGW;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_pl;
  logic          accept;
  logic          drain;

  assign in_pl = {ctrl_in, aluresult_in, storedata_in, rd_in};

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Derived only from the state register, so no combinational path from out_ready.
      assign in_ready = (state_q != StTwo);
    end else begin : g_noskid
      // Same-cycle replace lets a back-to-back stream run without bubbles.
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Incoming payload is discarded; data registers keep stale values.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_pl;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_d = in_pl;
          end else if (accept) begin
            // Only reachable with SKID=1; with SKID=0 an accept here implies a drain.
            skid_d  = in_pl;
            state_d = StTwo;
          end else if (drain) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign ctrl_out      = out_valid ? main_q[PW-1 -: CTRLW] : '0;
  assign aluresult_out = main_q[2*XLEN+REGW-1 -: XLEN];
  assign storedata_out = main_q[XLEN+REGW-1 -: XLEN];
  assign rd_out        = main_q[REGW-1:0];
  assign fwd_regwrite  = out_valid & ctrl_out[0] & (rd_out != '0);
  assign occupancy     = state_q;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
module tb_exmem_pipe_reg;

  logic        clk;
  logic        rst;

  // SKID=1 instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fwd;
  logic [3:0]  a_ctrl_in, a_ctrl_out;
  logic [31:0] a_alu_in, a_sd_in, a_alu_out, a_sd_out;
  logic [4:0]  a_rd_in, a_rd_out;
  logic [1:0]  a_occ;

  // SKID=0 instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fwd;
  logic [3:0]  b_ctrl_in, b_ctrl_out;
  logic [31:0] b_alu_in, b_sd_in, b_alu_out, b_sd_out;
  logic [4:0]  b_rd_in, b_rd_out;
  logic [1:0]  b_occ;

  int checks;
  int fails;

  exmem_pipe_reg #(.XLEN(32), .REGW(5), .CTRLW(4), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ctrl_in(a_ctrl_in), .aluresult_in(a_alu_in), .storedata_in(a_sd_in), .rd_in(a_rd_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .ctrl_out(a_ctrl_out), .aluresult_out(a_alu_out), .storedata_out(a_sd_out),
    .rd_out(a_rd_out), .fwd_regwrite(a_fwd), .occupancy(a_occ)
  );

  exmem_pipe_reg #(.XLEN(32), .REGW(5), .CTRLW(4), .SKID(0)) u_dut_noskid (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ctrl_in(b_ctrl_in), .aluresult_in(b_alu_in), .storedata_in(b_sd_in), .rd_in(b_rd_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ctrl_out(b_ctrl_out), .aluresult_out(b_alu_out), .storedata_out(b_sd_out),
    .rd_out(b_rd_out), .fwd_regwrite(b_fwd), .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    a_ctrl_in = 4'b0; a_alu_in = 32'h0; a_sd_in = 32'h0; a_rd_in = 5'd0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    b_ctrl_in = 4'b0; b_alu_in = 32'h0; b_sd_in = 32'h0; b_rd_in = 5'd0;

    // Reset held for two cycles
    step();
    step();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_ctrl_out", a_ctrl_out, 4'h0);
    chk("rst_fwd", a_fwd, 1'b0);
    chk("rst_occ", a_occ, 2'd0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1'b1);

    // Stream 0x10, 0x20, 0x30 with out_ready=1
    a_out_ready = 1; a_in_valid = 1; a_ctrl_in = 4'b0001; a_rd_in = 5'd1;
    a_alu_in = 32'h10;
    step();
    chk("s1_valid", a_out_valid, 1'b1);
    chk("s1_alu", a_alu_out, 32'h10);
    chk("s1_in_ready", a_in_ready, 1'b1);
    chk("s1_occ", a_occ, 2'd1);
    a_alu_in = 32'h20;
    step();
    chk("s2_alu", a_alu_out, 32'h20);
    chk("s2_in_ready", a_in_ready, 1'b1);
    a_alu_in = 32'h30;
    step();
    chk("s3_alu", a_alu_out, 32'h30);
    chk("s3_occ", a_occ, 2'd1);
    a_in_valid = 0;
    step();
    chk("s_end_valid", a_out_valid, 1'b0);
    chk("s_end_ctrl", a_ctrl_out, 4'h0);
    chk("s_end_fwd", a_fwd, 1'b0);

    // Backpressure: A then B into a stalled stage
    a_out_ready = 0; a_in_valid = 1; a_ctrl_in = 4'b0001; a_rd_in = 5'd3;
    a_alu_in = 32'hA; a_sd_in = 32'hAA;
    step();
    chk("bp_occ1", a_occ, 2'd1);
    chk("bp_alu_a", a_alu_out, 32'hA);
    a_alu_in = 32'hB; a_sd_in = 32'hBB;
    step();
    chk("bp_occ2", a_occ, 2'd2);
    chk("bp_in_ready0", a_in_ready, 1'b0);
    chk("bp_hold_alu", a_alu_out, 32'hA);
    chk("bp_hold_sd", a_sd_out, 32'hAA);
    a_in_valid = 0;
    step();
    chk("bp_hold2_alu", a_alu_out, 32'hA);
    chk("bp_hold2_occ", a_occ, 2'd2);
    a_out_ready = 1;
    step();
    chk("bp_drain1_alu", a_alu_out, 32'hB);
    chk("bp_drain1_sd", a_sd_out, 32'hBB);
    chk("bp_drain1_occ", a_occ, 2'd1);
    chk("bp_in_ready1", a_in_ready, 1'b1);
    step();
    chk("bp_drain2_occ", a_occ, 2'd0);
    chk("bp_drain2_valid", a_out_valid, 1'b0);

    // Flush from TWO with an incoming payload
    a_out_ready = 0; a_in_valid = 1; a_ctrl_in = 4'b0101; a_rd_in = 5'd7;
    a_alu_in = 32'h1;
    step();
    a_alu_in = 32'h2;
    step();
    chk("fl_pre_occ", a_occ, 2'd2);
    a_flush = 1; a_alu_in = 32'hC;
    step();
    chk("fl_valid", a_out_valid, 1'b0);
    chk("fl_ctrl", a_ctrl_out, 4'h0);
    chk("fl_occ", a_occ, 2'd0);
    chk("fl_in_ready", a_in_ready, 1'b1);
    // Flush in EMPTY must still beat an accept
    a_alu_in = 32'hD;
    step();
    chk("fl_empty_occ", a_occ, 2'd0);
    chk("fl_empty_valid", a_out_valid, 1'b0);
    a_flush = 0; a_in_valid = 0;
    step();
    chk("fl_after_valid", a_out_valid, 1'b0);

    // Forwarding tag
    a_out_ready = 1; a_in_valid = 1; a_ctrl_in = 4'b0001; a_rd_in = 5'd0;
    a_alu_in = 32'h40;
    step();
    chk("fw_rd0", a_fwd, 1'b0);
    chk("fw_rd0_valid", a_out_valid, 1'b1);
    a_rd_in = 5'd5;
    step();
    chk("fw_rd5", a_fwd, 1'b1);
    chk("fw_rd5_rd", a_rd_out, 5'd5);
    a_in_valid = 0;
    step();
    chk("fw_bubble", a_fwd, 1'b0);

    // Reset mid-store
    a_out_ready = 0; a_in_valid = 1; a_ctrl_in = 4'b0100; a_rd_in = 5'd9;
    a_alu_in = 32'h50; a_sd_in = 32'h55;
    step();
    chk("ms_ctrl", a_ctrl_out, 4'b0100);
    chk("ms_sd", a_sd_out, 32'h55);
    a_in_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("ms_rst_ctrl", a_ctrl_out, 4'h0);
    chk("ms_rst_valid", a_out_valid, 1'b0);
    chk("ms_rst_alu", a_alu_out, 32'h0);
    chk("ms_rst_sd", a_sd_out, 32'h0);
    chk("ms_rst_rd", a_rd_out, 5'd0);
    chk("ms_rst_occ", a_occ, 2'd0);
    chk("ms_rst_in_ready", a_in_ready, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk("ms_after_valid", a_out_valid, 1'b0);

    // SKID=0: back-to-back stream
    b_out_ready = 1; b_in_valid = 1; b_ctrl_in = 4'b0001; b_rd_in = 5'd2;
    b_alu_in = 32'h100;
    #1;
    chk("b0_in_ready", b_in_ready, 1'b1);
    step();
    chk("b1_alu", b_alu_out, 32'h100);
    chk("b1_in_ready", b_in_ready, 1'b1);
    b_alu_in = 32'h101;
    step();
    chk("b2_alu", b_alu_out, 32'h101);
    chk("b2_occ", b_occ, 2'd1);
    b_alu_in = 32'h102;
    step();
    chk("b3_alu", b_alu_out, 32'h102);
    // Stall: in_ready follows ~out_valid combinationally
    b_out_ready = 0; b_alu_in = 32'h200;
    #1;
    chk("b_stall_in_ready", b_in_ready, 1'b0);
    step();
    chk("b_stall_hold", b_alu_out, 32'h102);
    chk("b_stall_occ", b_occ, 2'd1);
    b_out_ready = 1;
    #1;
    chk("b_release_in_ready", b_in_ready, 1'b1);
    step();
    chk("b_replace_alu", b_alu_out, 32'h200);
    b_in_valid = 0; b_out_ready = 0;
    step();
    chk("b_idle_hold", b_alu_out, 32'h200);
    b_out_ready = 1;
    step();
    chk("b_drained_valid", b_out_valid, 1'b0);
    b_out_ready = 0;
    #1;
    chk("b_empty_in_ready", b_in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
